fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the async FIFO. Runs entirely in the FIFO read domain.
//  Pops datawidth-bit words via rempty/rdata/rinc and packs pack_words of them
//  into one wide beat. Presents each beat on a valid/ready stream interface.
//  Sits directly downstream of the FIFO and drives its rinc.
// PARAMETERS
//  datawidth      8   FIFO word width; must match the FIFO instance.
//  pack_words     4   words per output beat; power of 2, >=2.
//  cnt_width      2   log2(pack_words); width of the word counter.
//  timeout_cycles 16  idle cycles before a partial beat flushes (macro only); >=1.
// PORTS
//  rclk     in   1                      read-domain clock, same as FIFO rclk.
//  rrst     in   1                      async reset, active-high.
//  rempty   in   1                      FIFO empty flag.
//  rdata    in   datawidth              FIFO head word; valid whenever rempty=0.
//  rinc     out  1                      pop strobe to FIFO.
//  m_data   out  pack_words*datawidth   packed beat; word 0 at LSBs.
//  m_keep   out  pack_words             per-word valid mask.
//  m_valid  out  1                      beat valid.
//  m_ready  in   1                      downstream accept.
// BEHAVIOUR
//  Clock/reset: one clock rclk; rrst is asynchronous, active-high.
//  Reset values:
//   - m_valid=0, m_data=0.
//   - m_keep=0 with the macro; constant all-ones without it.
//   - Internal cnt=0, accumulator=0, idle counter=0.
//   - rinc=0 while rrst=1.
//  State:
//   - acc: pack_words-1 word slots.
//   - cnt: words held in acc, range 0..pack_words-1.
//   - Output register: m_data, m_keep, m_valid.
//  Pop rule:
//   - out_free = !m_valid | m_ready.
//   - rinc = !rempty & !rrst & ((cnt != pack_words-1) | out_free). Combinational.
//   - rinc is never high while rempty=1.
//  Word take (rinc=1), cnt<pack_words-1:
//   - acc[cnt] <= rdata; cnt <= cnt+1.
//  Word take, cnt=pack_words-1:
//   - m_data <= {rdata, acc}; m_keep <= all-ones; m_valid <= 1; cnt <= 0.
//  Latency and throughput:
//   - m_valid rises on the edge that samples the last word's rinc.
//   - 1 word/cycle sustained; 1 beat per pack_words cycles with m_ready=1.
//  Handshake:
//   - Transfer occurs when m_valid & m_ready.
//   - m_data and m_keep hold stable while m_valid=1 and m_ready=0.
//   - m_valid clears after a transfer unless a new beat loads the same cycle.
//  Boundaries:
//   - rempty=1 mid-pack: cnt holds and the partial word set waits.
//   - Output full with m_ready=0 and cnt=pack_words-1: rinc=0, back-pressuring
//     the FIFO.
//   - cnt wraps pack_words-1 -> 0 only on beat load.
//   - Reset mid-pack: accumulated words are discarded. Words already popped are
//     lost; this is accepted.
// CONFIGURATION
//  Macro: PACK_TIMEOUT_EN.
//  Defined:
//   - An idle counter increments each cycle with cnt>0 and rinc=0.
//   - It clears on any word take or flush.
//   - At idle=timeout_cycles with out_free=1, a partial beat loads:
//     m_data = acc words 0..cnt-1, upper words zero.
//     m_keep = low cnt bits set.
//     m_valid <= 1; cnt <= 0.
//   - A word take in the same cycle wins; no flush occurs that cycle.
//  Undefined:
//   - No idle counter; m_keep tied all-ones.
//   - Partial beats are never emitted.
// TESTING
//  1. rrst=1, rempty=0 -> rinc=0, m_valid=0, m_data=0. Release -> pops start next cycle.
//  2. FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 -> rinc high 4 cycles. Then
//     m_data=0x44332211, m_keep=4'hF, m_valid=1 for exactly 1 cycle.
//  3. Push 0x01..0x08 with m_ready=0 -> beat 0x04030201 holds. 0x05..0x07 are
//     absorbed, then rinc=0 with rempty=0. Raise m_ready -> beats 0x04030201,
//     then 0x08070605.
//  4. rempty toggles every cycle while 4 words arrive -> single beat, correct
//     order, no duplicates or drops.
//  5. PACK_TIMEOUT_EN: pop 0xAA,0xBB, then 16 empty cycles -> m_data=0x0000BBAA,
//     m_keep=4'b0011. Without the macro: no beat, cnt stays 2.
//  6. Assert rrst at cnt=2 -> m_valid=0, cnt=0. Then 0xD0..0xD3 -> beat
//     0xD3D2D1D0 with no stale words.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//   Read-side consumer of the async FIFO, clocked entirely in the read domain.
//   Pops datawidth-bit words from the FIFO and packs pack_words of them into
//   one wide beat, presented on a valid/ready stream.
//
//   Optional feature (macro PACK_TIMEOUT_EN): a partial beat is flushed after
//   timeout_cycles idle cycles. Without the macro only full beats are emitted
//   and m_keep is tied all-ones.
//
// Ports
//   rclk     in   read-domain clock (same as the FIFO rclk)
//   rrst     in   asynchronous active-high reset
//   rempty   in   FIFO empty flag
//   rdata    in   FIFO head word, valid whenever rempty=0
//   rinc     out  pop strobe to the FIFO (combinational)
//   m_data   out  packed beat, word 0 at the LSBs
//   m_keep   out  per-word valid mask
//   m_valid  out  beat valid
//   m_ready  in   downstream accept
//
// Stream handshake: a beat transfers on any rising rclk where m_valid and
// m_ready are both 1. While m_valid=1 and m_ready=0, m_data and m_keep hold.
// m_valid never drops without a transfer. m_ready may depend combinationally
// on m_valid, but m_valid never depends on m_ready in the same cycle.
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
   parameter int datawidth      = 8,
   parameter int pack_words     = 4,
   parameter int cnt_width      = 2,
   parameter int timeout_cycles = 16
) (
   input  logic                            rclk,
   input  logic                            rrst,
   input  logic                            rempty,
   input  logic [datawidth-1:0]            rdata,
   output logic                            rinc,
   output logic [pack_words*datawidth-1:0] m_data,
   output logic [pack_words-1:0]           m_keep,
   output logic                            m_valid,
   input  logic                            m_ready
);

   localparam int                   acc_width = (pack_words - 1) * datawidth;
   localparam logic [cnt_width-1:0] last_cnt  = cnt_width'(pack_words - 1);

   // Elaboration-time parameter sanity checks.
   if (pack_words < 2 || (1 << cnt_width) != pack_words) begin : g_bad_pack
      $error("fifo_rd_packer: pack_words must be a power of 2 >= 2 equal to 2**cnt_width");
   end
   if (timeout_cycles < 1) begin : g_bad_timeout
      $error("fifo_rd_packer: timeout_cycles must be >= 1");
   end

   // The last word of a beat is never stored in acc: it goes straight from
   // rdata into the output register, so acc only needs pack_words-1 slots.
   logic [acc_width-1:0] acc;
   logic [cnt_width-1:0] cnt;
   logic                 out_free;
   logic                 take;

   assign out_free = !m_valid || m_ready;

   // Only the final word of a beat needs room in the output register; the
   // others can always be absorbed into acc.
   assign rinc = !rempty && !rrst && ((cnt != last_cnt) || out_free);
   assign take = rinc;

`ifdef PACK_TIMEOUT_EN
   localparam int                    idle_width = $clog2(timeout_cycles + 1);
   localparam logic [idle_width-1:0] idle_max   = idle_width'(timeout_cycles);

   logic [idle_width-1:0]           idle;
   logic                            flush;
   logic [pack_words*datawidth-1:0] flush_data;
   logic [pack_words-1:0]           flush_keep;

   // A word take in the same cycle wins over a flush.
   assign flush = (cnt != '0) && !take && (idle == idle_max) && out_free;

   // Slots at or above cnt may hold words from an earlier beat; mask them.
   always_comb begin
      flush_data = '0;
      flush_keep = '0;
      for (int i = 0; i < pack_words - 1; i++) begin
         if (i < int'(cnt)) begin
            flush_data[i*datawidth +: datawidth] = acc[i*datawidth +: datawidth];
            flush_keep[i]                        = 1'b1;
         end
      end
   end

   // Idle counter saturates at idle_max while the output is blocked, so the
   // flush fires as soon as the output frees up.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         idle <= '0;
      end else if (take || flush) begin
         idle <= '0;
      end else if ((cnt != '0) && (idle != idle_max)) begin
         idle <= idle + 1'b1;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         m_keep <= '0;
      end else if (take && (cnt == last_cnt)) begin
         m_keep <= '1;
      end else if (flush) begin
         m_keep <= flush_keep;
      end
   end
`else
   assign m_keep = '1;
`endif

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         cnt     <= '0;
         acc     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
      end else begin
         // Transfer clears valid; a beat loaded this same cycle overrides it.
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (take) begin
            if (cnt == last_cnt) begin
               m_data  <= {rdata, acc};
               m_valid <= 1'b1;
               cnt     <= '0;
            end else begin
               acc[cnt*datawidth +: datawidth] <= rdata;
               cnt                             <= cnt + 1'b1;
            end
         end
`ifdef PACK_TIMEOUT_EN
         else if (flush) begin
            m_data  <= flush_data;
            m_valid <= 1'b1;
            cnt     <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//   Self-checking bench for fifo_rd_packer. A queue models the FIFO; every
//   word pushed is also grouped into an expected beat on exp_q, and beats
//   leaving the DUT are popped and compared. Inputs change on the falling
//   edge, outputs are sampled 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

   localparam int DW = 8;
   localparam int PW = 4;
   localparam int CW = 2;
   localparam int TO = 16;
   localparam int BW = PW * DW;

   // ---------------- clock / reset ----------------
   logic rclk = 1'b0;
   logic rrst = 1'b1;
   always #5 rclk = ~rclk;

   logic          rempty;
   logic [DW-1:0] rdata;
   logic          rinc;
   logic [BW-1:0] m_data;
   logic [PW-1:0] m_keep;
   logic          m_valid;
   logic          m_ready = 1'b0;

   fifo_rd_packer #(
      .datawidth     (DW),
      .pack_words    (PW),
      .cnt_width     (CW),
      .timeout_cycles(TO)
   ) dut (
      .rclk   (rclk),
      .rrst   (rrst),
      .rempty (rempty),
      .rdata  (rdata),
      .rinc   (rinc),
      .m_data (m_data),
      .m_keep (m_keep),
      .m_valid(m_valid),
      .m_ready(m_ready)
   );

   // ---------------- scoreboard state ----------------
   logic [DW-1:0]    fifo_q[$];
   logic [BW+PW-1:0] exp_q[$];   // {keep, data}
   logic [DW-1:0]    grp[PW];
   int               grp_n = 0;
   logic             stall = 1'b0;
   int               n_vec = 0;
   int               n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void refresh();
      rempty = (fifo_q.size() == 0) || stall;
      rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic push_word(input logic [DW-1:0] w);
      logic [BW-1:0] beat;
      fifo_q.push_back(w);
      grp[grp_n] = w;
      grp_n++;
      if (grp_n == PW) begin
         for (int i = 0; i < PW; i++) beat[i*DW +: DW] = grp[i];
         exp_q.push_back({{PW{1'b1}}, beat});
         grp_n = 0;
      end
      refresh();
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!m_valid && n < budget) begin
         @(negedge rclk); #1;
         n++;
      end
      check(tag, 64'(m_valid), 64'd1);
   endtask

   // ---------------- FIFO model pop ----------------
   logic took;
   logic empty_at_edge;
   always @(posedge rclk) begin
      took          = rinc;
      empty_at_edge = rempty;
      #1;
      if (took) begin
         check("rinc_vs_rempty", 64'(empty_at_edge), 64'd0);
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      refresh();
   end

   // ---------------- output monitor ----------------
   logic [BW+PW-1:0] exp_beat;
   always @(negedge rclk) begin
      #1;
      if (!rrst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(exp_q.size()), 64'd1);
         end else begin
            exp_beat = exp_q.pop_front();
            check("beat_data", 64'(m_data), 64'(exp_beat[BW-1:0]));
            check("beat_keep", 64'(m_keep), 64'(exp_beat[BW +: PW]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      refresh();
      // 1. reset with data available
      for (int i = 1; i <= 4; i++) push_word(DW'(8'h11 * i));
      repeat (2) @(negedge rclk);
      #1;
      check("rst_rinc", 64'(rinc), 64'd0);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_data", 64'(m_data), 64'd0);
`ifdef PACK_TIMEOUT_EN
      check("rst_keep", 64'(m_keep), 64'd0);
`else
      check("rst_keep", 64'(m_keep), 64'hF);
`endif
      @(negedge rclk);
      rrst    = 1'b0;
      m_ready = 1'b1;
      #1;
      check("release_rinc", 64'(rinc), 64'd1);

      // 2. single full beat 0x44332211, valid for one cycle
      wait_valid("t2_valid", 10);
      check("t2_data", 64'(m_data), 64'h44332211);
      @(negedge rclk); #1;
      check("t2_valid_one_cycle", 64'(m_valid), 64'd0);

      // 3. back-pressure
      @(negedge rclk);
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push_word(DW'(i));
      repeat (12) @(negedge rclk);
      #1;
      check("t3_rinc_blocked", 64'(rinc), 64'd0);
      check("t3_left_in_fifo", 64'(fifo_q.size()), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("t3_hold_valid", 64'(m_valid), 64'd1);
         check("t3_hold_data", 64'(m_data), 64'h04030201);
         @(negedge rclk); #1;
      end
      @(negedge rclk);
      m_ready = 1'b1;
      repeat (10) @(negedge rclk);
      #1;
      check("t3_drained", 64'(exp_q.size()), 64'd0);

      // 4. rempty toggling while words arrive
      @(negedge rclk);
      for (int i = 0; i < 4; i++) push_word(DW'(8'h61 + i));
      for (int i = 0; i < 12; i++) begin
         @(negedge rclk);
         stall = ~stall;
         refresh();
      end
      @(negedge rclk);
      stall = 1'b0;
      refresh();
      repeat (6) @(negedge rclk);
      #1;
      check("t4_drained", 64'(exp_q.size()), 64'd0);
      check("t4_fifo_empty", 64'(fifo_q.size()), 64'd0);

      // 5. partial beat behaviour
      @(negedge rclk);
      push_word(8'hAA);
      push_word(8'hBB);
`ifdef PACK_TIMEOUT_EN
      exp_q.push_back({4'b0011, 32'h0000BBAA});
      grp_n = 0;
      repeat (25) @(negedge rclk);
      #1;
      check("t5_flushed", 64'(exp_q.size()), 64'd0);
      @(negedge rclk);
      push_word(8'hC0);
      push_word(8'hC1);
      repeat (3) @(negedge rclk);
`else
      repeat (25) @(negedge rclk);
      #1;
      check("t5_no_partial", 64'(m_valid), 64'd0);
`endif

      // 6. reset mid-pack (two words held in acc)
      @(negedge rclk);
      rrst  = 1'b1;
      grp_n = 0;
      #1;
      check("t6_rst_valid", 64'(m_valid), 64'd0);
      check("t6_rst_rinc", 64'(rinc), 64'd0);
      @(negedge rclk);
      rrst = 1'b0;
      for (int i = 0; i < 4; i++) push_word(DW'(8'hD0 + i));
      wait_valid("t6_valid", 10);
      check("t6_data", 64'(m_data), 64'hD3D2D1D0);
      repeat (4) @(negedge rclk);
      #1;
      check("final_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
